seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
//   Round-robin arbiter sharing the 4-digit seven-segment display between N_REQ clients.
//   Each client presents a 16-bit hex value; the granted client's value drives number_0..3.
//   A minimum dwell time keeps each owner on the display long enough to read.
//   Sits between the design's status sources (FIFO counters etc.) and seven_segment_digit.
// PARAMETERS
//   N_REQ  4         number of requesters (>=2)
//   DWELL  25000000  minimum ownership time, clk cycles (>=1)
//   CNT_W  $clog2(DWELL+1)  dwell counter width (derived, localparam)
// PORTS
//   clk        in   1         system clock
//   rst        in   1         synchronous reset, active-high
//   req        in   N_REQ     per-client request, level-sensitive
//   req_value  in   N_REQ*16  client i value at [16*i +: 16]
//   ack        out  N_REQ     one-cycle pulse: client granted this cycle
//   grant      out  N_REQ     one-hot current owner; all-zero when idle
//   owner_idx  out  $clog2(N_REQ)  index of current/last owner
//   number_0   out  4         value[3:0]   (rightmost digit)
//   number_1   out  4         value[7:4]
//   number_2   out  4         value[11:8]
//   number_3   out  4         value[15:12]
// BEHAVIOUR
//   - Clock is clk; reset is rst, synchronous and active-high. All outputs registered.
//   - Reset: state=IDLE, grant=0, ack=0, owner_idx=0, number_0..3=0, dwell cnt=0,
//     rr pointer=N_REQ-1 (client 0 wins first). Reset mid-HOLD/OPEN aborts ownership.
//   - States: IDLE, HOLD, OPEN.
//   - IDLE: if |req: winner = first set req scanning ptr+1 upward, wrapping;
//     same edge: grant=onehot(winner), ack[winner]=1, owner_idx=winner, ptr=winner,
//     display regs <= req_value[winner], cnt <= DWELL-1, -> HOLD. Latency: 1 cycle.
//   - HOLD: cnt decrements each cycle. If cnt!=0 stay. If cnt==0 apply OPEN decision.
//   - OPEN decision (in OPEN, or HOLD with cnt==0):
//       other client (req & ~grant) pending -> grant next rr winner after owner,
//         ack pulse, reload value, cnt<=DWELL-1, -> HOLD;
//       else owner req low -> IDLE, grant=0, display keeps last value;
//       else -> OPEN (owner keeps display indefinitely).
//   - Minimum ownership is exactly DWELL cycles (grant at edge E0, earliest change E_DWELL).
//   - Live update: in HOLD/OPEN, while req[owner]=1, display regs load req_value[owner]
//     every cycle; while req[owner]=0 they hold. Non-owner values ignored.
//   - ack is single-cycle; never asserted for a client already owning.
//   - DWELL=1: HOLD lasts one cycle; switch possible every cycle.
//   - Simultaneous requests: rr order only; no priority beyond pointer.
// STRUCTURE
//   - seg_disp_pkg: typedef enum logic [1:0] {IDLE,HOLD,OPEN} seg_arb_state_t;
//     localparams NUM_DIGITS=4, DIGIT_W=4, VALUE_W=16.
//   - Sub-module seg_rr_picker (combinational): inputs req, ptr, mask;
//     outputs found, winner index (first set bit after ptr, wrapping).
//   - Top: FSM, dwell counter, ptr/owner regs, display value reg, output split.
// TESTING (N_REQ=4, DWELL=4)
//   1. rst high 2 cycles mid-HOLD -> grant=0, ack=0, numbers=0, IDLE; next req[0] wins.
//   2. IDLE, req[2]=1, value 16'h1234 -> next edge grant=4'b0100, ack=4'b0100 for 1 cycle,
//      number_3..0 = 1,2,3,4.
//   3. Out of reset, req[0]&req[3] same cycle -> grant=4'b0001 (ptr=3 -> 0 first).
//   4. Owner 1 granted at E0, req[3] high from E1 -> grant stays 4'b0010 through E3,
//      switches to 4'b1000 with ack[3] at E4.
//   5. Owner 1 drops req at E1 after value 16'hABCD, no others -> grant held to E3,
//      IDLE at E4, grant=0, numbers still D,C,B,A; live update stops at E1.
//   6. All req held high -> grant 0,1,2,3,0 each exactly 4 cycles, one ack per switch.

Source files
------------

// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and display geometry for the seven-segment display arbiter.
package seg_disp_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, OPEN} seg_arb_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int VALUE_W    = 16;
endpackage

// File: rtl/seg_display_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester (req & mask) after ptr, wrapping.
module seg_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [IDX_W-1:0] winner
);
  // Scan farthest offset first so the nearest hit after ptr is the one that sticks.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx] && mask[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum dwell per owner and
// live update of the owner's value while it keeps requesting.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DWELL = 25000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*VALUE_W-1:0]   req_value,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   owner_idx,
  output logic [DIGIT_W-1:0]         number_0,
  output logic [DIGIT_W-1:0]         number_1,
  output logic [DIGIT_W-1:0]         number_2,
  output logic [DIGIT_W-1:0]         number_3
);
  localparam int CNT_W = $clog2(DWELL + 1);
  localparam int IDX_W = $clog2(N_REQ);

  seg_arb_state_t                 state, nstate;
  logic [CNT_W-1:0]               cnt;
  logic [IDX_W-1:0]               ptr;
  logic [VALUE_W-1:0]             value_q;
  logic [N_REQ-1:0][VALUE_W-1:0]  vals;
  logic [N_REQ-1:0]               pick_mask;
  logic                           found, decide, owner_req, do_grant, load_live;
  logic [IDX_W-1:0]               winner;

  assign vals      = req_value;
  assign owner_req = req[owner_idx];
  assign decide    = (state == OPEN) || (state == HOLD && cnt == '0);
  // While owned, the current owner is masked out so only a different client can win.
  assign pick_mask = (state == IDLE) ? {N_REQ{1'b1}} : ~grant;

  seg_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .mask   (pick_mask),
    .found  (found),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:      if (found) nstate = HOLD;
      HOLD, OPEN: begin
        if (decide) begin
          if (found)           nstate = HOLD;
          else if (!owner_req) nstate = IDLE;
          else                 nstate = OPEN;
        end
      end
      default:   nstate = IDLE;
    endcase
  end

  always_comb begin
    do_grant  = 1'b0;
    load_live = 1'b0;
    if (state == IDLE) do_grant = found;
    else begin
      do_grant  = decide && found;
      load_live = owner_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= '0;
      ack       <= '0;
      owner_idx <= '0;
      ptr       <= IDX_W'(N_REQ - 1);
      value_q   <= '0;
      cnt       <= '0;
    end else if (do_grant) begin
      grant     <= N_REQ'(1) << winner;
      ack       <= N_REQ'(1) << winner;
      owner_idx <= winner;
      ptr       <= winner;
      value_q   <= vals[winner];
      cnt       <= CNT_W'(DWELL - 1);
    end else begin
      ack <= '0;
      if (nstate == IDLE) grant <= '0;
      if (load_live && nstate != IDLE) value_q <= vals[owner_idx];
      if (state == HOLD && cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

  assign number_0 = value_q[0*DIGIT_W +: DIGIT_W];
  assign number_1 = value_q[1*DIGIT_W +: DIGIT_W];
  assign number_2 = value_q[2*DIGIT_W +: DIGIT_W];
  assign number_3 = value_q[3*DIGIT_W +: DIGIT_W];
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench: an ownership/age reference model predicts outputs per edge,
// a negedge monitor compares them against the arbiter.
module tb_seg_display_arbiter;
  localparam int N     = 4;
  localparam int DWELL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*16-1:0] req_value;
  logic [N-1:0]  ack, grant;
  logic [1:0]    owner_idx;
  logic [3:0]    number_0, number_1, number_2, number_3;

  seg_display_arbiter #(.N_REQ(N), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_value(req_value),
    .ack(ack), .grant(grant), .owner_idx(owner_idx),
    .number_0(number_0), .number_1(number_1), .number_2(number_2), .number_3(number_3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic [15:0] value;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: owner, how long it has owned, and the shown value.
  bit          m_idle = 1'b1;
  int          m_owner = 0;
  int          m_ptr = N - 1;
  int          m_age = 0;
  logic [15:0] m_disp = '0;
  logic [3:0]  m_ack = '0;

  function automatic int rr_find(logic [3:0] r, int p, int excl);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic grant_to(input int w);
    m_idle  = 1'b0;
    m_owner = w;
    m_ptr   = w;
    m_ack   = 4'(1) << w;
    m_disp  = req_value[16*w +: 16];
    m_age   = 1;
  endtask

  task automatic model_step();
    int w;
    exp_t e;
    m_ack = '0;
    if (rst) begin
      m_idle = 1'b1; m_owner = 0; m_ptr = N - 1; m_disp = '0; m_age = 0;
    end else if (m_idle) begin
      w = rr_find(req, m_ptr, -1);
      if (w >= 0) grant_to(w);
    end else begin
      w = (m_age >= DWELL) ? rr_find(req, m_owner, m_owner) : -1;
      if (w >= 0) grant_to(w);
      else if (m_age >= DWELL && !req[m_owner]) m_idle = 1'b1;
      else begin
        if (req[m_owner]) m_disp = req_value[16*m_owner +: 16];
        if (m_age < DWELL) m_age++;
      end
    end
    e.grant = m_idle ? 4'b0 : (4'(1) << m_owner);
    e.ack   = m_ack;
    e.owner = 2'(m_owner);
    e.value = m_disp;
    exp_q.push_back(e);
  endtask

  // Apply one cycle of inputs, let the DUT sample them, record the prediction.
  task automatic cyc(input logic r, input logic [3:0] q, input logic [63:0] v);
    rst = r; req = q; req_value = v;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", 16'(grant), 16'(e.grant));
        chk("ack", 16'(ack), 16'(e.ack));
        chk("owner_idx", 16'(owner_idx), 16'(e.owner));
        chk("numbers", {number_3, number_2, number_1, number_0}, e.value);
      end
    end
  end

  initial begin
    logic [63:0] v;
    logic [3:0]  r;
    int          run;
    rst = 1'b1; req = '0; req_value = '0;
    #1;
    // Reset, then abort a HOLD with a 2-cycle reset; req[0]&req[3] -> client 0.
    cyc(1, 4'b0000, 64'h0);
    cyc(1, 4'b0000, 64'h0);
    cyc(0, 4'b0010, 64'h0000_0000_5555_0000);
    cyc(0, 4'b0010, 64'h0000_0000_6666_0000);
    cyc(1, 4'b0010, 64'h0);
    cyc(1, 4'b0000, 64'h0);
    cyc(0, 4'b1001, 64'h9999_0000_0000_1111);
    for (int i = 0; i < 6; i++) cyc(0, 4'b0000, 64'h0);
    // Single request from idle: client 2 with 1234.
    cyc(0, 4'b0100, 64'h0000_1234_0000_0000);
    for (int i = 0; i < 6; i++) cyc(0, 4'b0000, 64'h0);
    // Owner 1, client 3 waits from E1: switch exactly at E4.
    cyc(1, 4'b0000, 64'h0);
    cyc(0, 4'b0010, 64'h0000_0000_0101_0000);
    for (int i = 0; i < 7; i++) cyc(0, 4'b1010, 64'h3333_0000_0202_0000);
    // Owner 1 drops after ABCD: display freezes, IDLE at E4.
    cyc(1, 4'b0000, 64'h0);
    cyc(0, 4'b0010, 64'h0000_0000_ABCD_0000);
    for (int i = 0; i < 6; i++) cyc(0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF);
    // Everyone requesting: rotation 0,1,2,3,0 with DWELL cycles each.
    cyc(1, 4'b0000, 64'h0);
    for (int i = 0; i < 22; i++) cyc(0, 4'b1111, {16'h3000 + 16'(i), 16'h2000 + 16'(i), 16'h1000 + 16'(i), 16'(i)});
    // Random traffic with held request patterns and occasional resets.
    cyc(1, 4'b0000, 64'h0);
    for (int n = 0; n < 300; n++) begin
      r   = 4'($urandom_range(0, 15));
      run = $urandom_range(1, 10);
      for (int i = 0; i < run; i++) begin
        v = {$urandom, $urandom};
        cyc(($urandom_range(0, 199) == 0), r, v);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions left unchecked", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
